// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
// Optional match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

    localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1101;

    // Width of the history fill counter, which spans 0..pat_w-1.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register plus saturating fill counter for the pattern detector.
// The window presented to the comparator is {hist, current bit}.
module seq_hist_shreg
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             restart,
    input  logic             din,
    output logic [PAT_W-2:0] hist,
    output logic             full
);

    localparam int FILL_W = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [FILL_W-1:0] fill;

    // NOTE: synchronous clear of both registers; non-blocking so hist and fill update together.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= (PAT_W-1)'({hist, din});
            fill <= restart ? '0 : FILL_W'(sat_inc(32'(fill), 32'(FILL_MAX)));
        end
    end

    assign full = (fill == FILL_MAX);

endmodule

// File: rtl/param_sequence_detector.sv
// Mealy detector: out is high in the cycle the last PAT_W accepted bits equal pat.
// Define SEQ_DET_MATCH_CNT_EN to compile in the saturating match_cnt output.
module param_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1 || CNT_W > 32) begin : g_param_check
        $error("param_sequence_detector: PAT_W must be 2..32 and CNT_W 1..32");
    end

    logic [PAT_W-1:0] pat;
    logic [PAT_W-2:0] hist;
    logic             full;
    logic             accept;
    logic             match;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat <= DEFAULT_PAT;
        end else if (pat_load) begin
            pat <= pat_in;
        end
    end

    assign accept = in_valid && !pat_load && !reset;
    assign match  = accept && full && ({hist, in} == pat);
    assign out    = match;

    // A non-overlapping match restarts the fill count; stale hist bits are masked by full.
    seq_hist_shreg #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .clr      (pat_load),
        .restart  (match && !overlap),
        .din      (in),
        .hist     (hist),
        .full     (full)
    );

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset || pat_load) begin
            match_cnt <= '0;
        end else if (match) begin
            match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_MAX));
        end
    end
`endif

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed self-checking bench for param_sequence_detector (overlap, gaps, reload,
// reset, saturation); counter checks are compiled only with SEQ_DET_MATCH_CNT_EN.
module tb_param_sequence_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       din;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       overlap;
    logic       out;
    logic       out_sat;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_sat;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_sequence_detector #(.PAT_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (din),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .out       (out)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    param_sequence_detector #(.PAT_W(4), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (din),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .out       (out_sat)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt_sat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle, check out away from the edge, then move to just after the edge.
    task automatic step(input logic v, input logic b, input logic exp, input string tag);
        in_valid = v;
        din      = b;
        @(negedge clk);
        check(tag, {31'd0, out}, {31'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic b, input string tag);
        reset    = 1'b1;
        in_valid = v;
        din      = b;
        @(negedge clk);
        check(tag, {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_pat(input logic [3:0] p, input logic v, input logic b, input string tag);
        pat_load = 1'b1;
        pat_in   = p;
        in_valid = v;
        din      = b;
        @(negedge clk);
        check(tag, {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        pat_load = 1'b0;
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef SEQ_DET_MATCH_CNT_EN
        check(tag, {24'd0, match_cnt}, 32'(exp));
`endif
    endtask

    int stream [16] = '{1,1,0,1, 1,0,1,0, 1,1,0,1, 0,1,1,0};
    int exp_ov [16] = '{0,0,0,1, 0,0,1,0, 0,0,0,1, 0,0,0,0};
    int exp_no [16] = '{0,0,0,1, 0,0,0,0, 0,0,0,1, 0,0,0,0};
    int gap_bits [4] = '{1,1,0,1};
    int rl_pre [4]  = '{1,1,0,1};
    int rl_post [4] = '{0,1,1,0};

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        din      = 1'b0;
        pat_load = 1'b0;
        pat_in   = 4'b0000;
        overlap  = 1'b1;

        // Reset state, with a valid 1 on the wire to show out is masked.
        do_reset(1'b1, 1'b1, "reset out");
        check_cnt("reset cnt", 0);

        // Overlapping matches.
        overlap = 1'b1;
        for (int i = 0; i < 16; i++)
            step(1'b1, stream[i][0], exp_ov[i][0], $sformatf("ov bit %0d", i));
        check_cnt("ov cnt", 3);

        // Non-overlapping matches on the same stream.
        do_reset(1'b0, 1'b0, "reset before no-ov");
        overlap = 1'b0;
        for (int i = 0; i < 16; i++)
            step(1'b1, stream[i][0], exp_no[i][0], $sformatf("no-ov bit %0d", i));
        check_cnt("no-ov cnt", 2);

        // Idle cycles between accepted bits hold state and never flag.
        do_reset(1'b0, 1'b0, "reset before gaps");
        overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, gap_bits[i][0], (i == 3), $sformatf("gap bit %0d", i));
            step(1'b0, 1'b1, 1'b0, $sformatf("gap idle %0d", i));
        end
        check_cnt("gap cnt", 1);

        // Pattern reload: count cleared, load-cycle bit discarded, new pattern matches.
        do_reset(1'b0, 1'b0, "reset before reload");
        for (int i = 0; i < 4; i++)
            step(1'b1, rl_pre[i][0], (i == 3), $sformatf("pre-load bit %0d", i));
        check_cnt("pre-load cnt", 1);
        for (int i = 0; i < 3; i++)
            step(1'b1, rl_pre[i][0], 1'b0, $sformatf("partial bit %0d", i));
        load_pat(4'b0110, 1'b1, 1'b1, "load cycle out");
        check_cnt("load clears cnt", 0);
        for (int i = 0; i < 4; i++)
            step(1'b1, rl_post[i][0], (i == 3), $sformatf("post-load bit %0d", i));
        check_cnt("post-load cnt", 1);

        // Reset restores the default pattern and drops a partial window.
        do_reset(1'b0, 1'b0, "reset restores default");
        for (int i = 0; i < 3; i++)
            step(1'b1, rl_pre[i][0], 1'b0, $sformatf("pre-reset bit %0d", i));
        do_reset(1'b1, 1'b1, "mid-window reset out");
        for (int i = 0; i < 4; i++)
            step(1'b1, rl_pre[i][0], (i == 3), $sformatf("after-reset bit %0d", i));
        check_cnt("after-reset cnt", 1);

        // Saturation on the 2-bit counter instance with pattern 1111.
        overlap = 1'b1;
        load_pat(4'b1111, 1'b0, 1'b0, "sat load out");
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = 1'b1;
            @(negedge clk);
            check($sformatf("sat bit %0d", i), {31'd0, out_sat}, {31'd0, (i >= 3)});
            @(posedge clk);
            #1;
`ifdef SEQ_DET_MATCH_CNT_EN
            if (i == 4) check("sat cnt after bit 4", {30'd0, match_cnt_sat}, 32'd2);
            if (i == 7) check("sat cnt final", {30'd0, match_cnt_sat}, 32'd3);
`endif
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
